// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the execute stage, the debug requester, the data memory banks and dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [3:0]    cpu_wren;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_ack;
    logic [31:0]   dbg_rdata;

    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wren;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [CW-1:0] grant_cnt;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wren, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_stall, dbg_ack, dbg_rdata,
        output mem_addr, mem_wren, mem_wdata,
        output grant_cnt
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wren, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_stall, dbg_ack, dbg_rdata,
        input  mem_addr, mem_wren, mem_wdata,
        input  grant_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the byte-lane data memory banks between the CPU execute stage (priority) and a debug port.
// The debug port is granted for one cycle when the CPU is idle, or forcibly after STARVE_LIMIT waiting cycles.
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 16
) (
    input  logic           sysclk,
    input  logic           rstd,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_DBG,
        ST_ACK
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q,    state_d;
    logic [3:0]    waitCnt_q,  waitCnt_d;
    logic          dbgAck_q,   dbgAck_d;
    logic [31:0]   dbgRdata_q, dbgRdata_d;
    logic [CW-1:0] grantCnt_q, grantCnt_d;

    logic [AW-1:0] memAddr;
    logic [3:0]    memWren;
    logic [31:0]   memWdata;
    logic          cpuStall;

    // State and status registers; reset takes effect immediately, even mid-grant.
    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd) begin
            state_q    <= ST_CPU;
            waitCnt_q  <= 4'd0;
            dbgAck_q   <= 1'b0;
            dbgRdata_q <= 32'd0;
            grantCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            dbgAck_q   <= dbgAck_d;
            dbgRdata_q <= dbgRdata_d;
            grantCnt_q <= grantCnt_d;
        end
    end

    // cpu_stall is derived from state and cpu_req only, keeping dbg_req off the pipeline stall path.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        dbgAck_d   = dbgAck_q;
        dbgRdata_d = dbgRdata_q;
        grantCnt_d = grantCnt_q;
        memAddr    = bus.cpu_addr;
        memWdata   = bus.cpu_wdata;
        memWren    = bus.cpu_req ? bus.cpu_wren : 4'h0;
        cpuStall   = 1'b0;

        case (state_q)
            ST_CPU: begin
                if (bus.dbg_req) begin
                    if (!bus.cpu_req || waitCnt_q == LIMIT) begin
                        state_d   = ST_DBG;
                        waitCnt_d = 4'd0;
                    end else if (waitCnt_q < LIMIT) begin
                        waitCnt_d = waitCnt_q + 4'd1;
                    end
                end else begin
                    waitCnt_d = 4'd0;
                end
            end

            ST_DBG: begin
                memAddr    = bus.dbg_addr;
                memWdata   = bus.dbg_wdata;
                memWren    = bus.dbg_we ? 4'hF : 4'h0;
                cpuStall   = bus.cpu_req;
                dbgRdata_d = bus.mem_rdata;
                dbgAck_d   = 1'b1;
                grantCnt_d = grantCnt_q + 1'b1;
                state_d    = ST_ACK;
            end

            ST_ACK: begin
                dbgAck_d = 1'b0;
                state_d  = ST_CPU;
            end

            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    assign bus.mem_addr  = memAddr;
    assign bus.mem_wren  = memWren;
    assign bus.mem_wdata = memWdata;
    assign bus.cpu_stall = cpuStall;
    assign bus.dbg_ack   = dbgAck_q;
    assign bus.dbg_rdata = dbgRdata_q;
    assign bus.grant_cnt = grantCnt_q;

endmodule
